// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator issue queue: FSM state
// encoding, datapath width and the default tag width.
package accel_pkg;

  localparam int DATA_W    = 32;
  localparam int DEF_TAG_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT_Z = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/accel_issue_queue_if.sv
// Bundle of core-request, accelerator and core-response channels around the
// issue queue; slave is the queue itself, master is whoever drives it.
interface accel_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = accel_pkg::DEF_TAG_W
);
  import accel_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Every channel transfers on a rising clk edge where its valid/stb and its
  // ready/ack are both high; the producer holds data stable with valid/stb
  // high until that edge, and the consumer may raise or drop ready/ack freely.
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_tag;

  logic [DATA_W-1:0] output_a;
  logic              output_a_stb;
  logic              output_a_ack;
  logic [DATA_W-1:0] output_b;
  logic              output_b_stb;
  logic              output_b_ack;
  logic [DATA_W-1:0] input_z;
  logic              input_z_stb;
  logic              input_z_ack;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;

  logic [CNT_W-1:0]  count;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, req_tag,
    output req_ready,
    output output_a, output_a_stb, output_b, output_b_stb, input_z_ack,
    input  output_a_ack, output_b_ack, input_z, input_z_stb,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready,
    output count, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_tag,
    input  req_ready,
    input  output_a, output_a_stb, output_b, output_b_stb, input_z_ack,
    output output_a_ack, output_b_ack, input_z, input_z_stb,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready,
    input  count, busy
  );

endinterface

// File: rtl/accel_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while
// empty are dropped so the pointers can never slip.
module accel_sync_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/accel_issue_queue.sv
// Buffers core requests and issues them one at a time to a strobe/ack
// accelerator, returning each result with the tag of its request.
module accel_issue_queue
  import accel_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  accel_issue_queue_if.slave  bus,
  output state_e              dbg_state
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 2 * DATA_W + TAG_W;

  state_e            state;
  state_e            state_n;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] head;

  logic              a_stb_q;
  logic              b_stb_q;
  logic              z_ack_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic              z_take;

  // A full queue stays closed even if the FSM pops in the same cycle.
  assign bus.req_ready = !fifo_full;
  assign push          = bus.req_valid && !fifo_full;

  accel_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.req_a, bus.req_b, bus.req_tag}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign z_take = z_ack_q && bus.input_z_stb;

  // The FSM only sees the registered count, so a push into an empty queue
  // reaches it one cycle later.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_n = ST_SEND_A;
        end
      end
      ST_SEND_A: if (a_stb_q && bus.output_a_ack) state_n = ST_SEND_B;
      ST_SEND_B: if (b_stb_q && bus.output_b_ack) state_n = ST_WAIT_Z;
      ST_WAIT_Z: if (z_take) state_n = ST_RESP;
      ST_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = ST_SEND_A;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Handshake outputs are flopped from the next state so each is a clean
  // register that rises on entry to its state and drops on the transfer edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      z_ack_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      state       <= state_n;
      a_stb_q     <= (state_n == ST_SEND_A);
      b_stb_q     <= (state_n == ST_SEND_B);
      z_ack_q     <= (state_n == ST_WAIT_Z);
      rsp_valid_q <= (state_n == ST_RESP);
      if (pop) begin
        a_q   <= head[ENTRY_W-1 -: DATA_W];
        b_q   <= head[TAG_W +: DATA_W];
        tag_q <= head[TAG_W-1:0];
      end
      if (state == ST_WAIT_Z && z_take) begin
        rsp_data_q <= bus.input_z;
        rsp_tag_q  <= tag_q;
      end
    end
  end

  assign bus.output_a     = a_q;
  assign bus.output_a_stb = a_stb_q;
  assign bus.output_b     = b_q;
  assign bus.output_b_stb = b_stb_q;
  assign bus.input_z_ack  = z_ack_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_tag      = rsp_tag_q;
  assign bus.count        = fifo_count;
  assign bus.busy         = (state != ST_IDLE) || (fifo_count != '0);
  assign dbg_state        = state;

endmodule
